// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Converts a binary value to BCD with a sequential shift-add-3 (double
//   dabble) engine and time-multiplexes the result onto DIGITS common-anode
//   seven-segment digits, with optional leading-zero blanking.
//
// Parameters
//   DATA_W   width of the binary input (1..16)
//   DIGITS   number of scanned digits; must hold 2**DATA_W-1 in decimal
//   CLK_DIV  clocks per digit dwell (>= 1)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      single-cycle capture request, honoured only when idle
//   data      unsigned binary value to convert
//   blank_lz  1 = blank leading zeros (sampled live while scanning)
//   busy      high while a conversion is in progress
//   seg       {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables, active-low, an[0] = least significant digit
module seg_scan_display #(
  parameter int DATA_W  = 8,
  parameter int DIGITS  = 3,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              blank_lz,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Decimal digits needed to print the largest DATA_W-bit value.
  function automatic int min_digits(input int w);
    int unsigned v;
    int          n;
    v = (32'd1 << w) - 32'd1;
    n = 1;
    while (v >= 32'd10) begin
      v = v / 32'd10;
      n = n + 1;
    end
    return n;
  endfunction

  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("seg_scan_display: DATA_W must be in 1..16");
  end
  if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
    $error("seg_scan_display: DIGITS too small for DATA_W");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("seg_scan_display: CLK_DIV must be >= 1");
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // BCD nibble to active-low gfedcba glyph; anything above 9 is blank.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [1:0]        state_r;
  logic [DATA_W-1:0] bin_r;
  logic [BW-1:0]     work_r;
  logic [BW-1:0]     disp_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;

  logic [PW-1:0]     presc_r;
  logic [XW-1:0]     dig_r;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;

  logic [BW-1:0]     adj_s;
  logic [DIGITS-1:0] lz_vec_s;
  logic              zero_run_s;
  logic [3:0]        nib_s;
  logic              blank_s;
  logic [6:0]        glyph_s;
  logic [DIGITS-1:0] an_s;

  // Correction step applied to the work register in SHIFT.
  always_comb begin
    adj_s = dabble_adj(work_r);
  end

  // Converter FSM; the display register is only written from DONE so the
  // scanner never sees a half-converted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      bin_r   <= {DATA_W{1'b0}};
      work_r  <= {BW{1'b0}};
      disp_r  <= {BW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r   <= data;
            work_r  <= {BW{1'b0}};
            cnt_r   <= CW'(DATA_W);
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Shift {bcd,bin} left as one word; the bcd MSB falls off, which
          // is safe because DIGITS is large enough for the input range.
          {work_r, bin_r} <= {adj_s, bin_r} << 1'b1;
          cnt_r           <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          disp_r  <= work_r;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Leading-zero map: digit i (i > 0) is blankable when it and every digit
  // above it are zero. Digit 0 is never blanked.
  always_comb begin
    lz_vec_s   = {DIGITS{1'b0}};
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s  = zero_run_s & (disp_r[4*i +: 4] == 4'd0);
      lz_vec_s[i] = zero_run_s;
    end
  end

  // Glyph and anode pattern for the digit currently selected by the scanner.
  always_comb begin
    nib_s   = disp_r[{dig_r, 2'b00} +: 4];
    blank_s = blank_lz & lz_vec_s[dig_r];
    if (blank_s) begin
      glyph_s = 7'b1111111;
    end else begin
      glyph_s = glyph(nib_s);
    end
    an_s = ~(DIGITS'(1) << dig_r);
  end

  // Scanner: dwell prescaler; on each wrap present the selected digit and
  // advance the digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
      dig_r   <= {XW{1'b0}};
      seg_r   <= 7'b1111111;
      an_r    <= {DIGITS{1'b1}};
    end else begin
      if (presc_r == PW'(CLK_DIV - 1)) begin
        presc_r <= {PW{1'b0}};
        seg_r   <= glyph_s;
        an_r    <= an_s;
        if (dig_r == XW'(DIGITS - 1)) begin
          dig_r <= {XW{1'b0}};
        end else begin
          dig_r <= dig_r + XW'(1);
        end
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  assign busy = busy_r;
  assign seg  = seg_r;
  assign an   = an_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Directed bench for seg_scan_display (DATA_W=8, DIGITS=3, CLK_DIV=4).
//   A value-level model (decimal arithmetic on the displayed integer plus a
//   busy countdown) predicts seg/an/busy every cycle; directed literal
//   checks pin the model at the interesting points.
module tb_seg_scan_display;

  localparam int DATA_W  = 8;
  localparam int DIGITS  = 3;
  localparam int CLK_DIV = 4;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;

  localparam logic [6:0] GLYPH [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [7:0]  data;
  logic        blank_lz;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seg_scan_display #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data    (data),
    .blank_lz(blank_lz),
    .busy    (busy),
    .seg     (seg),
    .an      (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected glyph of decimal position i of value v.
  function automatic logic [6:0] model_glyph(input int v, input int i, input bit blz);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blz && i > 0 && v < p) return BLANK;
    return GLYPH[(v / p) % 10];
  endfunction

  int         m_edges;
  int         m_wraps;
  int         m_disp;
  int         m_pend;
  int         m_left;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;
  logic       exp_busy;

  // Reference model: edge count drives the scan, a countdown drives busy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges  <= 0;
      m_wraps  <= 0;
      m_disp   <= 0;
      m_pend   <= 0;
      m_left   <= 0;
      exp_seg  <= BLANK;
      exp_an   <= 3'b111;
      exp_busy <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      if ((m_edges + 1) % CLK_DIV == 0) begin
        exp_an  <= ~(3'b001 << (m_wraps % DIGITS));
        exp_seg <= model_glyph(m_disp, m_wraps % DIGITS, blank_lz);
        m_wraps <= m_wraps + 1;
      end
      if (m_left == 0) begin
        if (load) begin
          m_left   <= DATA_W + 1;
          m_pend   <= int'(data);
          exp_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_disp   <= m_pend;
          exp_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        checks = checks + 3;
        if (seg !== exp_seg) begin
          errors = errors + 1;
          $display("FAIL model_seg t=%0t: got %b want %b", $time, seg, exp_seg);
        end
        if (an !== exp_an) begin
          errors = errors + 1;
          $display("FAIL model_an t=%0t: got %b want %b", $time, an, exp_an);
        end
        if (busy !== exp_busy) begin
          errors = errors + 1;
          $display("FAIL model_busy t=%0t: got %b want %b", $time, busy, exp_busy);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    data = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout(name);
  endtask

  // Wait for a fresh scan of digit idx, then check its glyph.
  task automatic show_digit(input int idx, input logic [6:0] exp, input string name);
    logic [2:0] tgt;
    int n;
    bit expired;
    tgt = ~(3'b001 << idx);
    n = 0;
    expired = 1'b0;
    while (an == tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) expired = 1'b1;
    n = 0;
    while (an != tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) expired = 1'b1;
    if (expired) timeout(name);
    else check(name, {1'b0, seg}, {1'b0, exp});
  endtask

  initial begin
    int bcnt;
    rst_n    = 1'b1;
    load     = 1'b0;
    data     = 8'd0;
    blank_lz = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg", {1'b0, seg}, {1'b0, BLANK});
    check("rst_an", {5'd0, an}, 8'b0000_0111);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;

    // Scan timing: first tick on the 4th edge, then every 4 clocks.
    repeat (3) @(negedge clk);
    check("pre_tick_an", {5'd0, an}, 8'b0000_0111);
    @(negedge clk);
    check("tick1_an", {5'd0, an}, 8'b0000_0110);
    check("tick1_seg", {1'b0, seg}, {1'b0, G0});
    repeat (4) @(negedge clk);
    check("tick2_an", {5'd0, an}, 8'b0000_0101);
    repeat (4) @(negedge clk);
    check("tick3_an", {5'd0, an}, 8'b0000_0011);
    check("tick3_seg", {1'b0, seg}, {1'b0, G0});
    repeat (4) @(negedge clk);
    check("tick4_an", {5'd0, an}, 8'b0000_0110);

    // 255: busy exactly 9 cycles, then 5,5,2.
    pulse_load(8'd255);
    bcnt = 0;
    while (busy && bcnt < 30) begin
      bcnt++;
      @(negedge clk);
    end
    check("busy_len_255", 8'(bcnt), 8'd9);
    show_digit(0, G5, "d255_0");
    show_digit(1, G5, "d255_1");
    show_digit(2, G2, "d255_2");

    // 7 with and without leading-zero blanking.
    blank_lz = 1'b1;
    pulse_load(8'd7);
    wait_idle("idle_7");
    show_digit(0, G7, "d7_lz_0");
    show_digit(1, BLANK, "d7_lz_1");
    show_digit(2, BLANK, "d7_lz_2");
    blank_lz = 1'b0;
    show_digit(1, G0, "d7_nolz_1");
    show_digit(2, G0, "d7_nolz_2");

    // 105: interior zero stays visible.
    blank_lz = 1'b1;
    pulse_load(8'd105);
    wait_idle("idle_105");
    show_digit(0, G5, "d105_0");
    show_digit(1, G0, "d105_1");
    show_digit(2, G1, "d105_2");

    // 42 with loads during busy and on the falling cycle: both ignored.
    blank_lz = 1'b0;
    pulse_load(8'd42);
    @(negedge clk);
    @(negedge clk);
    pulse_load(8'd99);
    repeat (5) @(negedge clk);
    check("busy_last_cycle", {7'd0, busy}, 8'd1);
    pulse_load(8'd99);
    check("busy_fell", {7'd0, busy}, 8'd0);
    @(negedge clk);
    check("done_load_ignored", {7'd0, busy}, 8'd0);
    show_digit(0, G2, "d42_0");
    show_digit(1, G4, "d42_1");
    show_digit(2, G0, "d42_2");

    // Load on the first idle cycle after busy falls is accepted.
    pulse_load(8'd42);
    repeat (9) @(negedge clk);
    check("idle_after_42", {7'd0, busy}, 8'd0);
    pulse_load(8'd99);
    check("reload_accepted", {7'd0, busy}, 8'd1);
    wait_idle("idle_99");
    blank_lz = 1'b1;
    show_digit(0, G9, "d99_0");
    show_digit(1, G9, "d99_1");
    show_digit(2, BLANK, "d99_2");

    // Reset during SHIFT of 200 aborts with display cleared.
    blank_lz = 1'b0;
    pulse_load(8'd42);
    wait_idle("idle_42b");
    pulse_load(8'd200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_seg", {1'b0, seg}, {1'b0, BLANK});
    check("abort_an", {5'd0, an}, 8'b0000_0111);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_commit_busy", {7'd0, busy}, 8'd0);
    show_digit(0, G0, "rst0_0");
    show_digit(1, G0, "rst0_1");
    show_digit(2, G0, "rst0_2");
    blank_lz = 1'b1;
    show_digit(0, G0, "rst0_lz_0");
    show_digit(1, BLANK, "rst0_lz_1");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
